// File: rtl/reservation_station_pkg.sv
// Shared widths, op codes and entry types for the reservation station and its
// neighbours in the dispatch/issue path.
package reservation_station_pkg;

    localparam int OP_LEN      = 6;
    localparam int IMM_LEN     = 32;
    localparam int PC_LEN      = 32;
    localparam int ROB_LEN     = 4;
    localparam int INT_LEN     = 32;
    localparam int DATA_LEN    = 32;
    localparam int RS_SIZE_DEF = 16;
    localparam int RS_LEN_DEF  = 4;

    localparam logic [OP_LEN-1:0] OP_ADD = 6'd1;
    localparam logic [OP_LEN-1:0] OP_SUB = 6'd2;
    localparam logic [OP_LEN-1:0] OP_BEQ = 6'd3;
    localparam logic [OP_LEN-1:0] OP_JAL = 6'd4;

    // Fields that travel with an op unchanged from dispatch to issue.
    typedef struct packed {
        logic [OP_LEN-1:0]  op;
        logic [IMM_LEN-1:0] imm;
        logic [PC_LEN-1:0]  pc;
        logic [ROB_LEN-1:0] robpos;
    } rs_info_t;

    function automatic logic tag_hit(input logic flag,
                                     input logic [ROB_LEN-1:0] a,
                                     input logic [ROB_LEN-1:0] b);
        return flag && (a == b);
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder; used for both free-slot and ready-entry search.
module rs_select #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] index
);

    always_comb begin
        found = |req;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ops until both operands are known,
// snoops ALU/LSB broadcasts, and issues the lowest-index ready op each cycle.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int RS_LEN  = RS_LEN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ready,
    input  logic                clear,
    input  logic                dsp_valid,
    input  logic [OP_LEN-1:0]   dsp_op,
    input  logic [IMM_LEN-1:0]  dsp_imm,
    input  logic [PC_LEN-1:0]   dsp_pc,
    input  logic [ROB_LEN-1:0]  dsp_robpos,
    input  logic                dsp_qj_busy,
    input  logic [ROB_LEN-1:0]  dsp_qj,
    input  logic [INT_LEN-1:0]  dsp_vj,
    input  logic                dsp_qk_busy,
    input  logic [ROB_LEN-1:0]  dsp_qk,
    input  logic [INT_LEN-1:0]  dsp_vk,
    input  logic                alu_flag,
    input  logic [ROB_LEN-1:0]  alu_robpos,
    input  logic [DATA_LEN-1:0] alu_val,
    input  logic                lsb_flag,
    input  logic [ROB_LEN-1:0]  lsb_robpos,
    input  logic [DATA_LEN-1:0] lsb_val,
    output logic                rs_full,
    output logic                work,
    output logic [OP_LEN-1:0]   op,
    output logic [IMM_LEN-1:0]  imm,
    output logic [PC_LEN-1:0]   pc,
    output logic [ROB_LEN-1:0]  robpos,
    output logic [INT_LEN-1:0]  rs1,
    output logic [INT_LEN-1:0]  rs2
);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
    logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
    logic [ROB_LEN-1:0] qj_q [RS_SIZE];
    logic [ROB_LEN-1:0] qj_d [RS_SIZE];
    logic [ROB_LEN-1:0] qk_q [RS_SIZE];
    logic [ROB_LEN-1:0] qk_d [RS_SIZE];
    logic [INT_LEN-1:0] vj_q [RS_SIZE];
    logic [INT_LEN-1:0] vj_d [RS_SIZE];
    logic [INT_LEN-1:0] vk_q [RS_SIZE];
    logic [INT_LEN-1:0] vk_d [RS_SIZE];
    rs_info_t           info_q [RS_SIZE];
    rs_info_t           info_d [RS_SIZE];

    logic [RS_LEN:0]    count_q, count_d;
    logic               work_q, work_d;
    rs_info_t           out_info_q, out_info_d;
    logic [INT_LEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;

    logic [RS_SIZE-1:0] rdy_req;
    logic               free_found, rdy_found;
    logic [RS_LEN-1:0]  free_idx, rdy_idx;
    logic               do_dispatch;

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_rdy
            assign rdy_req[gi] = busy_q[gi] & ~qj_busy_q[gi] & ~qk_busy_q[gi];
        end
    endgenerate

    rs_select #(.N(RS_SIZE), .W(RS_LEN)) u_free_sel (
        .req   (~busy_q),
        .found (free_found),
        .index (free_idx)
    );

    rs_select #(.N(RS_SIZE), .W(RS_LEN)) u_rdy_sel (
        .req   (rdy_req),
        .found (rdy_found),
        .index (rdy_idx)
    );

    assign rs_full     = (count_q == (RS_LEN+1)'(RS_SIZE));
    assign do_dispatch = dsp_valid & ~rs_full & free_found;

    always_comb begin
        busy_d     = busy_q;
        qj_busy_d  = qj_busy_q;
        qk_busy_d  = qk_busy_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        info_d     = info_q;
        count_d    = count_q;
        work_d     = work_q;
        out_info_d = out_info_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;

        if (clear) begin
            busy_d  = '0;
            count_d = '0;
            work_d  = 1'b0;
        end else if (ready) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && qj_busy_q[i]) begin
                    if (tag_hit(alu_flag, qj_q[i], alu_robpos)) begin
                        vj_d[i]      = alu_val;
                        qj_busy_d[i] = 1'b0;
                    end else if (tag_hit(lsb_flag, qj_q[i], lsb_robpos)) begin
                        vj_d[i]      = lsb_val;
                        qj_busy_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qk_busy_q[i]) begin
                    if (tag_hit(alu_flag, qk_q[i], alu_robpos)) begin
                        vk_d[i]      = alu_val;
                        qk_busy_d[i] = 1'b0;
                    end else if (tag_hit(lsb_flag, qk_q[i], lsb_robpos)) begin
                        vk_d[i]      = lsb_val;
                        qk_busy_d[i] = 1'b0;
                    end
                end
            end

            // Select looks only at registered readiness, so a fresh wakeup waits a cycle.
            work_d = rdy_found;
            if (rdy_found) begin
                out_info_d      = info_q[rdy_idx];
                rs1_d           = vj_q[rdy_idx];
                rs2_d           = vk_q[rdy_idx];
                busy_d[rdy_idx] = 1'b0;
            end

            if (do_dispatch) begin
                busy_d[free_idx]    = 1'b1;
                info_d[free_idx]    = '{op: dsp_op, imm: dsp_imm, pc: dsp_pc, robpos: dsp_robpos};
                qj_busy_d[free_idx] = dsp_qj_busy;
                qj_d[free_idx]      = dsp_qj;
                vj_d[free_idx]      = dsp_vj;
                qk_busy_d[free_idx] = dsp_qk_busy;
                qk_d[free_idx]      = dsp_qk;
                vk_d[free_idx]      = dsp_vk;
                if (dsp_qj_busy && tag_hit(alu_flag, dsp_qj, alu_robpos)) begin
                    qj_busy_d[free_idx] = 1'b0;
                    vj_d[free_idx]      = alu_val;
                end else if (dsp_qj_busy && tag_hit(lsb_flag, dsp_qj, lsb_robpos)) begin
                    qj_busy_d[free_idx] = 1'b0;
                    vj_d[free_idx]      = lsb_val;
                end
                if (dsp_qk_busy && tag_hit(alu_flag, dsp_qk, alu_robpos)) begin
                    qk_busy_d[free_idx] = 1'b0;
                    vk_d[free_idx]      = alu_val;
                end else if (dsp_qk_busy && tag_hit(lsb_flag, dsp_qk, lsb_robpos)) begin
                    qk_busy_d[free_idx] = 1'b0;
                    vk_d[free_idx]      = lsb_val;
                end
            end

            count_d = count_q + (RS_LEN+1)'(do_dispatch) - (RS_LEN+1)'(rdy_found);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= '0;
            qj_busy_q  <= '0;
            qk_busy_q  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                info_q[i] <= '0;
            end
            count_q    <= '0;
            work_q     <= 1'b0;
            out_info_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            qj_busy_q  <= qj_busy_d;
            qk_busy_q  <= qk_busy_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            info_q     <= info_d;
            count_q    <= count_d;
            work_q     <= work_d;
            out_info_q <= out_info_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
        end
    end

    assign work   = work_q;
    assign op     = out_info_q.op;
    assign imm    = out_info_q.imm;
    assign pc     = out_info_q.pc;
    assign robpos = out_info_q.robpos;
    assign rs1    = rs1_q;
    assign rs2    = rs2_q;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and a randomized run against a slot-array reference model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int N = RS_SIZE_DEF;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                ready = 1'b1;
    logic                clear = 1'b0;
    logic                dsp_valid = 1'b0;
    logic [OP_LEN-1:0]   dsp_op = '0;
    logic [IMM_LEN-1:0]  dsp_imm = '0;
    logic [PC_LEN-1:0]   dsp_pc = '0;
    logic [ROB_LEN-1:0]  dsp_robpos = '0;
    logic                dsp_qj_busy = 1'b0;
    logic [ROB_LEN-1:0]  dsp_qj = '0;
    logic [INT_LEN-1:0]  dsp_vj = '0;
    logic                dsp_qk_busy = 1'b0;
    logic [ROB_LEN-1:0]  dsp_qk = '0;
    logic [INT_LEN-1:0]  dsp_vk = '0;
    logic                alu_flag = 1'b0;
    logic [ROB_LEN-1:0]  alu_robpos = '0;
    logic [DATA_LEN-1:0] alu_val = '0;
    logic                lsb_flag = 1'b0;
    logic [ROB_LEN-1:0]  lsb_robpos = '0;
    logic [DATA_LEN-1:0] lsb_val = '0;
    logic                rs_full, work;
    logic [OP_LEN-1:0]   o_op;
    logic [IMM_LEN-1:0]  o_imm;
    logic [PC_LEN-1:0]   o_pc;
    logic [ROB_LEN-1:0]  o_robpos;
    logic [INT_LEN-1:0]  o_rs1, o_rs2;

    reservation_station #(.RS_SIZE(N), .RS_LEN(RS_LEN_DEF)) dut (
        .clk(clk), .reset(reset), .ready(ready), .clear(clear),
        .dsp_valid(dsp_valid), .dsp_op(dsp_op), .dsp_imm(dsp_imm), .dsp_pc(dsp_pc),
        .dsp_robpos(dsp_robpos), .dsp_qj_busy(dsp_qj_busy), .dsp_qj(dsp_qj), .dsp_vj(dsp_vj),
        .dsp_qk_busy(dsp_qk_busy), .dsp_qk(dsp_qk), .dsp_vk(dsp_vk),
        .alu_flag(alu_flag), .alu_robpos(alu_robpos), .alu_val(alu_val),
        .lsb_flag(lsb_flag), .lsb_robpos(lsb_robpos), .lsb_val(lsb_val),
        .rs_full(rs_full), .work(work), .op(o_op), .imm(o_imm), .pc(o_pc),
        .robpos(o_robpos), .rs1(o_rs1), .rs2(o_rs2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dsp_valid   = 1'b0;
        dsp_qj_busy = 1'b0;
        dsp_qk_busy = 1'b0;
        alu_flag    = 1'b0;
        lsb_flag    = 1'b0;
        clear       = 1'b0;
    endtask

    // Directed dispatch; imm/pc are derived from the tag so issue can be cross-checked.
    task automatic disp(input logic [OP_LEN-1:0] o, input logic [ROB_LEN-1:0] tag,
                        input logic jb, input logic [ROB_LEN-1:0] qj, input logic [INT_LEN-1:0] vj,
                        input logic kb, input logic [ROB_LEN-1:0] qk, input logic [INT_LEN-1:0] vk);
        dsp_valid   = 1'b1;
        dsp_op      = o;
        dsp_robpos  = tag;
        dsp_imm     = 32'h100 + IMM_LEN'(tag);
        dsp_pc      = 32'h4000 + (PC_LEN'(tag) << 2);
        dsp_qj_busy = jb;
        dsp_qj      = qj;
        dsp_vj      = vj;
        dsp_qk_busy = kb;
        dsp_qk      = qk;
        dsp_vk      = vk;
    endtask

    task automatic chk_issue(input string name, input logic [OP_LEN-1:0] eop,
                             input logic [ROB_LEN-1:0] etag,
                             input logic [INT_LEN-1:0] e1, input logic [INT_LEN-1:0] e2);
        chk({name, ".work"}, work, 1'b1);
        chk({name, ".op"}, o_op, eop);
        chk({name, ".robpos"}, o_robpos, etag);
        chk({name, ".rs1"}, o_rs1, e1);
        chk({name, ".rs2"}, o_rs2, e2);
        chk({name, ".imm"}, o_imm, 32'h100 + IMM_LEN'(etag));
        chk({name, ".pc"}, o_pc, 32'h4000 + (PC_LEN'(etag) << 2));
    endtask

    typedef struct {
        logic                dv;
        logic [OP_LEN-1:0]   op;
        logic [ROB_LEN-1:0]  tag;
        logic                jb;
        logic [ROB_LEN-1:0]  qj;
        logic [INT_LEN-1:0]  vj;
        logic                kb;
        logic [ROB_LEN-1:0]  qk;
        logic [INT_LEN-1:0]  vk;
        logic [1:0]          bsrc;   // 0 none, 1 ALU, 2 LSB
        logic [ROB_LEN-1:0]  btag;
        logic [DATA_LEN-1:0] bval;
        logic                ew;
        logic [OP_LEN-1:0]   eop;
        logic [ROB_LEN-1:0]  etag;
        logic [INT_LEN-1:0]  e1;
        logic [INT_LEN-1:0]  e2;
    } vec_t;

    vec_t tbl[13];

    // Reference model: one record per slot, scanned in index order.
    typedef struct {
        bit                 used;
        logic [OP_LEN-1:0]  op;
        logic [IMM_LEN-1:0] imm;
        logic [PC_LEN-1:0]  pc;
        logic [ROB_LEN-1:0] tag;
        bit                 jw;
        logic [ROB_LEN-1:0] jt;
        logic [INT_LEN-1:0] jv;
        bit                 kw;
        logic [ROB_LEN-1:0] kt;
        logic [INT_LEN-1:0] kv;
    } slot_t;

    slot_t              m[N];
    logic               m_work;
    logic [OP_LEN-1:0]  m_op;
    logic [IMM_LEN-1:0] m_imm;
    logic [PC_LEN-1:0]  m_pc;
    logic [ROB_LEN-1:0] m_tag;
    logic [INT_LEN-1:0] m_rs1, m_rs2;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m[i].used = 0;
        m_work = 0; m_op = '0; m_imm = '0; m_pc = '0; m_tag = '0; m_rs1 = '0; m_rs2 = '0;
    endtask

    function automatic int model_used();
        int c = 0;
        for (int i = 0; i < N; i++) if (m[i].used) c++;
        return c;
    endfunction

    task automatic snoop(input logic [ROB_LEN-1:0] t, inout bit w, inout logic [INT_LEN-1:0] v);
        if (!w) return;
        if (alu_flag && t == alu_robpos) begin v = alu_val; w = 0; end
        else if (lsb_flag && t == lsb_robpos) begin v = lsb_val; w = 0; end
    endtask

    task automatic model_step();
        int sel = -1;
        int fr  = -1;
        int cnt = model_used();
        for (int i = 0; i < N; i++) begin
            if (m[i].used) begin
                if (!m[i].jw && !m[i].kw && sel < 0) sel = i;
            end else if (fr < 0) begin
                fr = i;
            end
        end
        if (clear) begin
            for (int i = 0; i < N; i++) m[i].used = 0;
            m_work = 0;
        end else if (ready) begin
            for (int i = 0; i < N; i++) begin
                if (m[i].used) begin
                    snoop(m[i].jt, m[i].jw, m[i].jv);
                    snoop(m[i].kt, m[i].kw, m[i].kv);
                end
            end
            m_work = (sel >= 0);
            if (sel >= 0) begin
                m_op = m[sel].op; m_imm = m[sel].imm; m_pc = m[sel].pc; m_tag = m[sel].tag;
                m_rs1 = m[sel].jv; m_rs2 = m[sel].kv;
                m[sel].used = 0;
            end
            if (dsp_valid && cnt < N) begin
                m[fr].used = 1; m[fr].op = dsp_op; m[fr].imm = dsp_imm; m[fr].pc = dsp_pc;
                m[fr].tag = dsp_robpos;
                m[fr].jw = dsp_qj_busy; m[fr].jt = dsp_qj; m[fr].jv = dsp_vj;
                m[fr].kw = dsp_qk_busy; m[fr].kt = dsp_qk; m[fr].kv = dsp_vk;
                snoop(m[fr].jt, m[fr].jw, m[fr].jv);
                snoop(m[fr].kt, m[fr].kw, m[fr].kv);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1, OP_ADD, 3, 0, 0, 5,  0, 0, 7, 0, 0, 0,    0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0, 0,    1, OP_ADD, 3, 5, 7};
        tbl[2]  = '{0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0};
        tbl[3]  = '{1, OP_SUB, 4, 1, 2, 0,  0, 0, 1, 0, 0, 0,    0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0,      0, 0, 0,  0, 0, 0, 1, 2, 'h10, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0, 0,    1, OP_SUB, 4, 'h10, 1};
        tbl[6]  = '{1, OP_BEQ, 6, 0, 0, 3,  1, 5, 0, 2, 5, 9,    0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0, 0,    1, OP_BEQ, 6, 3, 9};
        tbl[8]  = '{0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0};
        tbl[9]  = '{1, OP_JAL, 8, 0, 0, 1,  0, 0, 2, 0, 0, 0,    0, 0, 0, 0, 0};
        tbl[10] = '{1, OP_ADD, 9, 0, 0, 3,  0, 0, 4, 0, 0, 0,    1, OP_JAL, 8, 1, 2};
        tbl[11] = '{0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0, 0,    1, OP_ADD, 9, 3, 4};
        tbl[12] = '{0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0};

        // Reset values.
        tick();
        tick();
        chk("reset.work", work, 1'b0);
        chk("reset.rs_full", rs_full, 1'b0);
        chk("reset.op", o_op, '0);
        chk("reset.robpos", o_robpos, '0);
        chk("reset.rs1", o_rs1, '0);
        chk("reset.rs2", o_rs2, '0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Vector table.
        for (int r = 0; r < 13; r++) begin
            idle();
            if (tbl[r].dv)
                disp(tbl[r].op, tbl[r].tag, tbl[r].jb, tbl[r].qj, tbl[r].vj,
                     tbl[r].kb, tbl[r].qk, tbl[r].vk);
            alu_flag   = (tbl[r].bsrc == 2'd1);
            lsb_flag   = (tbl[r].bsrc == 2'd2);
            alu_robpos = tbl[r].btag;
            lsb_robpos = tbl[r].btag;
            alu_val    = tbl[r].bval;
            lsb_val    = tbl[r].bval;
            tick();
            $display("vec %0d: work=%0d robpos=%0d rs1=%0h rs2=%0h", r, work, o_robpos, o_rs1, o_rs2);
            chk($sformatf("vec%0d.work", r), work, tbl[r].ew);
            chk($sformatf("vec%0d.rs_full", r), rs_full, 1'b0);
            if (tbl[r].ew)
                chk_issue($sformatf("vec%0d", r), tbl[r].eop, tbl[r].etag, tbl[r].e1, tbl[r].e2);
        end
        idle();

        // Fill all entries blocked on tag 7, try one more, then release them.
        for (int i = 0; i < N; i++) begin
            disp(OP_ADD, ROB_LEN'(i), 1, 7, 0, 0, 0, INT_LEN'(i));
            tick();
        end
        chk("fill.rs_full", rs_full, 1'b1);
        disp(OP_SUB, 15, 0, 0, 32'h99, 0, 0, 32'h98);
        tick();
        chk("fill.drop_full", rs_full, 1'b1);
        chk("fill.drop_work", work, 1'b0);
        idle();
        alu_flag = 1'b1; alu_robpos = 7; alu_val = 32'h77;
        tick();
        chk("fill.wake_same_cycle", work, 1'b0);
        idle();
        for (int i = 0; i < N; i++) begin
            tick();
            $display("fill issue %0d: robpos=%0d rs1=%0h rs_full=%0d", i, o_robpos, o_rs1, rs_full);
            chk_issue($sformatf("fill%0d", i), OP_ADD, ROB_LEN'(i), 32'h77, INT_LEN'(i));
            if (i == 0) chk("fill.full_drops", rs_full, 1'b0);
        end
        tick();
        chk("fill.no_dropped_issue", work, 1'b0);

        // Clear with four blocked entries while work is high.
        disp(OP_ADD, 10, 1, 9, 0, 0, 0, 1); tick();
        disp(OP_ADD, 11, 1, 9, 0, 0, 0, 2); tick();
        disp(OP_ADD, 12, 1, 9, 0, 0, 0, 3); tick();
        disp(OP_JAL, 1, 0, 0, 32'hA, 0, 0, 32'hB); tick();
        disp(OP_ADD, 13, 1, 9, 0, 0, 0, 4); tick();
        chk_issue("clr.pre", OP_JAL, 1, 32'hA, 32'hB);
        idle();
        clear = 1'b1;
        disp(OP_SUB, 14, 0, 0, 1, 0, 0, 1);
        alu_flag = 1'b1; alu_robpos = 9; alu_val = 32'h5;
        tick();
        $display("clear: work=%0d rs_full=%0d", work, rs_full);
        chk("clr.work", work, 1'b0);
        chk("clr.rs_full", rs_full, 1'b0);
        idle();
        alu_flag = 1'b1; alu_robpos = 9; alu_val = 32'h6;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("clr.no_issue%0d", i), work, 1'b0);
        end

        // ready low holds a ready entry and ignores dispatch.
        disp(OP_ADD, 2, 0, 0, 32'h21, 0, 0, 32'h22);
        tick();
        chk("hold.after_dsp", work, 1'b0);
        idle();
        ready = 1'b0;
        disp(OP_SUB, 3, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold.stall%0d", i), work, 1'b0);
        end
        idle();
        ready = 1'b1;
        tick();
        chk_issue("hold.resume", OP_ADD, 2, 32'h21, 32'h22);
        tick();
        chk("hold.dropped", work, 1'b0);

        // Asynchronous reset between edges.
        disp(OP_ADD, 5, 0, 0, 32'h55, 0, 0, 32'h66); tick();
        disp(OP_ADD, 6, 0, 0, 32'h1, 0, 0, 32'h2); tick();
        idle();
        chk_issue("arst.pre", OP_ADD, 5, 32'h55, 32'h66);
        #2;
        reset = 1'b0;
        #1;
        $display("async reset: work=%0d robpos=%0d rs1=%0h", work, o_robpos, o_rs1);
        chk("arst.work", work, 1'b0);
        chk("arst.robpos", o_robpos, '0);
        chk("arst.rs1", o_rs1, '0);
        chk("arst.rs2", o_rs2, '0);
        chk("arst.op", o_op, '0);
        chk("arst.pc", o_pc, '0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("arst.cleared", work, 1'b0);

        // Randomized run against the reference model.
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 500; c++) begin
            idle();
            ready = ($urandom_range(0, 7) != 0);
            clear = ($urandom_range(0, 63) == 0);
            if (model_used() < N && $urandom_range(0, 3) != 0) begin
                dsp_valid   = 1'b1;
                dsp_op      = OP_LEN'($urandom_range(1, 4));
                dsp_imm     = $urandom;
                dsp_pc      = $urandom;
                dsp_robpos  = ROB_LEN'($urandom_range(0, 15));
                dsp_qj_busy = $urandom_range(0, 1) != 0;
                dsp_qj      = ROB_LEN'($urandom_range(0, 7));
                dsp_vj      = $urandom;
                dsp_qk_busy = $urandom_range(0, 1) != 0;
                dsp_qk      = ROB_LEN'($urandom_range(0, 7));
                dsp_vk      = $urandom;
            end
            alu_flag   = $urandom_range(0, 1) != 0;
            alu_robpos = ROB_LEN'($urandom_range(0, 7));
            alu_val    = $urandom;
            lsb_flag   = $urandom_range(0, 2) == 0;
            lsb_robpos = ROB_LEN'($urandom_range(0, 7));
            lsb_val    = $urandom;
            if (alu_flag && lsb_flag && alu_robpos == lsb_robpos) lsb_flag = 1'b0;
            model_step();
            tick();
            if (m_work)
                $display("rand %0d: issue robpos=%0d rs1=%0h rs2=%0h", c, m_tag, m_rs1, m_rs2);
            chk($sformatf("rand%0d.work", c), work, m_work);
            chk($sformatf("rand%0d.rs_full", c), rs_full, model_used() == N);
            chk($sformatf("rand%0d.op", c), o_op, m_op);
            chk($sformatf("rand%0d.imm", c), o_imm, m_imm);
            chk($sformatf("rand%0d.pc", c), o_pc, m_pc);
            chk($sformatf("rand%0d.robpos", c), o_robpos, m_tag);
            chk($sformatf("rand%0d.rs1", c), o_rs1, m_rs1);
            chk($sformatf("rand%0d.rs2", c), o_rs2, m_rs2);
        end
        idle();
        ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Holds dispatched integer/branch/jump ops until both source operands are available, then issues at most one ready op per cycle to the ALU. Sits between the decoder/dispatch stage and the ALU. It snoops the ALU and load/store result broadcasts to capture pending operands, and is flushed by the global misprediction `clear`.

## Interface
- `RS_SIZE`, default 16: number of entries, a power of two.
- `RS_LEN`, default 4: log2(`RS_SIZE`).
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-low; all state is cleared while low.
- `ready`, input, 1: global enable; when low, all state and outputs hold.
- `clear`, input, 1: synchronous flush on misprediction.
- `dsp_valid`, input, 1: dispatch request.
- `dsp_op`, input, `OP_LEN`: op code.
- `dsp_imm`, input, `IMM_LEN`: immediate.
- `dsp_pc`, input, `PC_LEN`: pc.
- `dsp_robpos`, input, `ROB_LEN`: ROB tag.
- `dsp_qj_busy`, input, 1: operand j pending.
- `dsp_qj`, input, `ROB_LEN`: producer tag for operand j.
- `dsp_vj`, input, `INT_LEN`: value of operand j.
- `dsp_qk_busy`, `dsp_qk`, `dsp_vk`: same as the j fields, for operand k.
- `alu_flag`, input, 1: ALU broadcast valid.
- `alu_robpos`, input, `ROB_LEN`: ALU broadcast tag.
- `alu_val`, input, `DATA_LEN`: ALU broadcast value.
- `lsb_flag`, `lsb_robpos`, `lsb_val`: load/store buffer broadcast, same meaning as the ALU fields.
- `rs_full`, output, 1: no free entry.
- `work`, output, 1: ALU issue valid.
- `op`, output, `OP_LEN`: issued op.
- `imm`, output, `IMM_LEN`: issued immediate.
- `pc`, output, `PC_LEN`: issued pc.
- `robpos`, output, `ROB_LEN`: issued tag.
- `rs1`, output, `INT_LEN`: operand j value.
- `rs2`, output, `INT_LEN`: operand k value.

## Operation
- Each entry holds: `busy`, `op`, `imm`, `pc`, `robpos`, `qj_busy`, `qj`, `vj`, `qk_busy`, `qk`, `vk`.
- Priority order, highest first: `reset` low, then `clear`, then `ready` low (hold), then normal operation.
- **Dispatch:** accepted only if `dsp_valid` and `rs_full` is 0. It writes the lowest-index free entry. While `rs_full` is 1, a dispatch is dropped with no state change; the dispatcher must not assert `dsp_valid` while full.
- **Dispatch bypass:** if an incoming `qj_busy`/`qk_busy` tag matches a broadcast in the same cycle, the entry is written with the operand marked ready and the broadcast value stored.
- **Wakeup:** every busy entry with `qX_busy` set and `qX` equal to a valid broadcast tag stores the value and clears `qX_busy`.
  - The ALU and LSB tags never collide; if both match, ALU wins.
  - Re-capturing a held broadcast is idempotent.
- **Select:** the lowest-index entry with `busy` set and both `q*_busy` clear.
  - Selection uses registered state only; an operand woken this cycle issues next cycle at the earliest.
- **Issue:** the selected entry's fields are registered onto the outputs and `work` is set to 1; the entry is freed in the same edge. With no ready entry, `work` goes to 0 and the other outputs hold their values.
- Dispatch, wakeup and issue may all happen in one cycle.
  - Dispatch cannot target the entry being freed that cycle.
  - `rs_full` is computed from the current count.
- **Counter:** `count` is `RS_LEN+1` bits. It takes +1 on dispatch, −1 on issue, and is unchanged when both occur. `rs_full` = (`count` == `RS_SIZE`).
- **`clear`:** all `busy` bits go to 0, `count` to 0, and `work` to 0 at the next edge. Dispatch and broadcasts in that cycle are ignored.

## Timing
- Reset values:
  - `work` = 0 and `rs_full` = 0.
  - `op`, `imm`, `pc`, `robpos`, `rs1`, `rs2` = 0.
  - All `busy` bits = 0.
- Minimum latency:
  - Dispatch with both operands ready at edge N (entry written).
  - `work` = 1 after edge N+1.
  - ALU captures at edge N+2.
- Pending operand: broadcast seen at edge M, then `work` can be 1 after edge M+1.
- `work` is a single-cycle pulse per entry; back-to-back issue of different entries is allowed every cycle.
- `reset` is asynchronous on assertion. Deassertion is synchronised upstream, so the block samples normally from the first edge after release.

## Structure
- Add `RS_SIZE` and `RS_LEN` to the shared `def.v` constants header alongside `OP_LEN`, `ROB_LEN`, etc.
- Sub-module `rs_select`: parameterised lowest-index priority encoder, instantiated twice.
  - Free-slot search over `~busy`.
  - Ready-entry search over `busy & ~qj_busy & ~qk_busy`.
  - Outputs: `found`, `index`.

## Test plan
- Dispatch ADD with tag 3, vj=5, vk=7, both ready → two cycles later `work`=1, `op`=ADD, `rs1`=5, `rs2`=7, `robpos`=3 for one cycle.
- Dispatch an op with qj=2 pending, then `alu_flag`=1, `alu_robpos`=2, `alu_val`=0x10 → the cycle after the broadcast, `work`=1 with `rs1`=0x10.
- Same-cycle bypass: dispatch with qk=5 while `lsb_flag`=1, `lsb_robpos`=5, `lsb_val`=9 → entry issues with `rs2`=9 and no further wakeup is needed.
- Fill 16 entries, all blocked on tag 7 → `rs_full`=1 and a 17th dispatch is dropped. Broadcast tag 7 → entries issue in index order 0..15, one per cycle, and `rs_full` drops after the first issue.
- Assert `clear` with 4 busy entries and `work`=1 → next cycle `work`=0 and `rs_full`=0; a later broadcast of their tags produces no issue.
- Pull `reset` low mid-operation, asynchronously between edges → outputs go to their reset values immediately. Hold `ready`=0 with a ready entry → no issue until `ready` returns.
